// File: rtl/decoder5_32_q_pkg.sv
// Shared register-clear constants and types.
// Common to the 32-to-5 clear encoder, this decoder and the register-status table.
package decoder5_32_q_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int REG_NUM    = 32;

  // Encoder output when no clear line is active.
  localparam logic [REG_ADDR_W-1:0] IDLE_ADDR = 5'b11111;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
  typedef logic [REG_NUM-1:0]    reg_vec_t;

  // One-hot expansion of a register index. Bit positions match the encoder.
  function automatic reg_vec_t addr_to_onehot(input reg_addr_t addr);
    reg_vec_t vec;
    vec       = '0;
    vec[addr] = 1'b1;
    return vec;
  endfunction

endpackage

// File: rtl/decoder5_32_q_if.sv
// Request / clear-pulse bundle between the commit side and the clear decoder.
// The master side issues clear requests and applies Stall.
// The slave side is the decoder.
interface decoder5_32_q_if #(
  parameter int DEPTH = 4,
  parameter int PTR_W = $clog2(DEPTH)
);
  import decoder5_32_q_pkg::*;

  reg_addr_t        Addr;
  logic             Clear_en;
  logic             Ready;
  logic             Stall;
  reg_vec_t         wen1_rst;
  logic             Valid_out;
  logic [PTR_W:0]   Count;
  logic             Drop;

  modport master (
    output Addr, Clear_en, Stall,
    input  Ready, wen1_rst, Valid_out, Count, Drop
  );

  modport slave (
    input  Addr, Clear_en, Stall,
    output Ready, wen1_rst, Valid_out, Count, Drop
  );

endinterface

// File: rtl/decoder5_32_q_sync_fifo_ptr.sv
// Small synchronous FIFO with an explicit occupancy counter.
// DEPTH must be a power of two (>= 2) so that the pointers wrap naturally.
// Full and empty come from the counter, so equal pointers are never ambiguous.
module sync_fifo_ptr #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 5,
  parameter int PTR_W  = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic [DATA_W-1:0] din,
  input  logic              pop,
  output logic [DATA_W-1:0] dout,
  output logic [PTR_W:0]    count,
  output logic              full,
  output logic              empty
);

  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wptr;
  logic [PTR_W-1:0]  rptr;
  logic [PTR_W:0]    cnt;
  logic              push_ok;
  logic              pop_ok;

  assign full    = (cnt == FULL_CNT);
  assign empty   = (cnt == '0);
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;
  assign dout    = mem[rptr];
  assign count   = cnt;

  // Storage write; contents need no reset because the counter gates every read.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wptr] <= din;
    end
  end

  // Pointer and occupancy update; a simultaneous push and pop leaves cnt unchanged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else begin
      if (push_ok) begin
        wptr <= wptr + 1'b1;
      end
      if (pop_ok) begin
        rptr <= rptr + 1'b1;
      end
      case ({push_ok, pop_ok})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/decoder5_32_q.sv
// Buffered 5-to-32 register-clear decoder.
// Queues clear requests and drains one per cycle as a registered one-hot pulse.
// The output is always zero or one-hot, so the 32-to-5 encoder maps it back to
// the original index, or to IDLE_ADDR with Clear_en=0 when the output is idle.
module decoder5_32_q
  import decoder5_32_q_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  decoder5_32_q_if.slave        bus
);

  localparam int PTR_W = $clog2(DEPTH);

  reg_addr_t        fifo_dout;
  logic [PTR_W:0]   fifo_count;
  logic             fifo_full;
  logic             fifo_empty;
  logic             push;
  logic             pop;
  logic             ready;

  reg_vec_t         wen_q;
  logic             valid_q;
  logic             drop_q;

  // Ready depends only on registered occupancy. A full queue refuses a push
  // even on an edge where it also pops.
  assign ready = ~fifo_full;
  assign push  = bus.Clear_en & ready;
  assign pop   = ~fifo_empty & ~bus.Stall;

  sync_fifo_ptr #(
    .DEPTH  (DEPTH),
    .DATA_W (REG_ADDR_W),
    .PTR_W  (PTR_W)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .din   (bus.Addr),
    .pop   (pop),
    .dout  (fifo_dout),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // One-cycle clear pulse per popped entry; zero on every other cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wen_q   <= '0;
      valid_q <= 1'b0;
    end else if (pop) begin
      wen_q   <= addr_to_onehot(fifo_dout);
      valid_q <= 1'b1;
    end else begin
      wen_q   <= '0;
      valid_q <= 1'b0;
    end
  end

  // Sticky record of any refused request; only reset clears it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_q <= 1'b0;
    end else if (bus.Clear_en && !ready) begin
      drop_q <= 1'b1;
    end
  end

  assign bus.Ready     = ready;
  assign bus.wen1_rst  = wen_q;
  assign bus.Valid_out = valid_q;
  assign bus.Count     = fifo_count;
  assign bus.Drop      = drop_q;

endmodule

// File: doc/decoder5_32_q.md
Name: decoder5_32_q

Overview:
- Buffered 5-to-32 one-hot decoder. It is the inverse of the 32-to-5 register-clear encoder.
- Accepts register-clear requests (5-bit address plus enable) from the commit/broadcast side and queues them in a small FIFO.
- Drains one request per cycle as a registered one-hot 32-bit pulse on wen1_rst, which drives the register-status table's per-register reset lines.
- The output is bit-compatible with the encoder: feeding wen1_rst into it returns the same Addr with Clear_en=1, and an idle output returns 5'b11111 with Clear_en=0.

Parameters:
- DEPTH, 4, FIFO entries. Must be a power of 2 and at least 2.
- PTR_W, 2, log2(DEPTH). Derived; never overridden independently.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- Addr  input  5  register index to clear.
- Clear_en  input  1  request valid. Qualifies Addr.
- Ready  output  1  FIFO can accept a request this cycle.
- Stall  input  1  downstream hold. While high, no pop occurs.
- wen1_rst  output  32  registered one-hot clear pulse. All zero when idle.
- Valid_out  output  1  registered. High exactly when wen1_rst is non-zero.
- Count  output  PTR_W+1  current FIFO occupancy, 0..DEPTH.
- Drop  output  1  sticky flag. Set when Clear_en=1 while Ready=0.

Behaviour:
- Reset (rst_n low, async): wen1_rst=0, Valid_out=0, Count=0, Drop=0, read/write pointers=0, Ready=1.
  - Takes effect immediately, mid-operation included. All queued entries are discarded.
- Ready = (Count != DEPTH). Combinational from registered Count only; no path from Clear_en or Stall.
- Push: at a rising edge with Clear_en=1 and Ready=1, Addr is written at wptr, then wptr is incremented modulo DEPTH.
- Pop: at a rising edge with Count!=0 and Stall=0:
  - wen1_rst <= 32'h1 << fifo[rptr], Valid_out <= 1, rptr increments modulo DEPTH.
  - Otherwise wen1_rst <= 0 and Valid_out <= 0.
  - Each entry therefore produces exactly one one-cycle pulse.
- No bypass. A request sampled at edge k into an empty FIFO appears on wen1_rst after edge k+1 and clears after edge k+2 if nothing else is queued. Minimum latency is 2 edges.
- Throughput: one pop per cycle. Back-to-back requests give back-to-back pulses with no idle gap.
- Simultaneous push and pop: both happen and Count is unchanged.
  - When full, Ready=0, so the push is refused even if a pop occurs that same edge. This is the chosen conservative policy.
- Empty with Stall=0: wen1_rst stays 0. Stall with data queued: output goes 0 and the queue is held.
- Drop: set on any edge where Clear_en=1 and Ready=0. The request is lost. Cleared only by reset.
- Duplicate addresses are not merged. Each queued entry yields its own pulse.
- Pointer wrap: pointers are PTR_W bits and wrap naturally. Full versus empty is distinguished by Count, not by pointer equality.
- Invariant: wen1_rst is zero or one-hot at every cycle. Never multi-hot.

Decomposition:
- Shared package constants: REG_ADDR_W=5, REG_NUM=32, IDLE_ADDR=5'b11111. These are shared with the 32-to-5 encoder and the status table.
- One natural sub-module: sync_fifo_ptr, a DEPTH-parameterised FIFO storing 5-bit entries with Count, full and empty.
- The one-hot decode and output register stay in the top level.

Test Plan:
- Single request: reset, then Addr=5'd7 with Clear_en=1 for one cycle -> wen1_rst=32'h00000080, Valid_out=1 for exactly one cycle, 2 edges after the request; then 0. Count goes 1 then 0.
- Burst of 4 with Stall=1, addresses 0, 1, 30, 31 -> Count=4, Ready=0. Release Stall -> 4 consecutive pulses 32'h1, 32'h2, 32'h40000000, 32'h80000000. Ready returns to 1 after the first pop.
- Overflow: with Count=4, assert Clear_en with Addr=5 -> Drop=1 and Count stays 4. Drained output contains no 32'h20. Drop stays 1 until reset.
- Wrap-around: 10 requests (addresses 0..9) with simultaneous push and pop each cycle -> 10 pulses in order. Count never exceeds 1, and pointers wrap twice.
- Async reset mid-burst: 3 entries queued and wen1_rst=32'h4; drop rst_n between edges -> all outputs 0 and Ready=1 immediately, with no pulses after release.
- Round trip: connect wen1_rst to the 32-to-5 encoder and sweep all 32 addresses -> encoder Addr equals the input address with Clear_en=1 each pulse cycle. In idle cycles it outputs 5'b11111 with Clear_en=0.
